// File: rtl/vga_fill.sv
// Rectangle fill engine: CPU-programmed bus master that paints a solid 4-bit colour
// into the 4 bpp framebuffer, using read-modify-write only on partially covered words.
module vga_fill #(
    parameter int unsigned FB_W = 424,
    parameter int unsigned FB_H = 240,
    parameter int unsigned WPL  = 53
) (
    input  logic        clk,
    input  logic        reset_ni,
    input  logic        sel_i,
    input  logic        wr_en_i,
    input  logic [2:0]  address_in_i,
    input  logic [31:0] data_in_i,
    output logic [31:0] data_out_o,
    output logic        ack_o,
    output logic        m_sel_o,
    output logic        m_wr_en_o,
    output logic [3:0]  m_wr_mask_o,
    output logic [15:0] m_address_o,
    output logic [31:0] m_data_o,
    input  logic [31:0] m_data_i,
    input  logic        m_ack_i,
    output logic        done_o
);
    localparam int unsigned AW = 15;
    localparam logic [10:0]   FB_W_X = 11'(FB_W);
    localparam logic [9:0]    FB_H_Y = 10'(FB_H);
    localparam logic [AW-1:0] WPL_A  = AW'(WPL);

    typedef enum logic [2:0] {S_IDLE, S_ROW, S_WORD, S_RD, S_WR, S_NEXT, S_DONE} state_t;
    state_t state, state_d;

    logic [8:0]    x0_r;
    logic [7:0]    y0_r;
    logic [9:0]    wid_r;
    logic [8:0]    hei_r;
    logic [3:0]    col_r;
    logic          go;

    logic [8:0]    wx0, wy, y_end;
    logic [9:0]    x_end;
    logic [3:0]    wcol;
    logic [AW-1:0] row_base, waddr;
    logic [5:0]    wcur;
    logic [31:0]   rd_data;
    logic          empty;

    logic [10:0]   x_sum;
    logic [9:0]    y_sum, x_end_c;
    logic [8:0]    y_end_c, x_last, wy_inc;
    logic [AW-1:0] base_c;
    logic          empty_c, busy, full, last_word, bus_done;
    logic [5:0]    first_w, last_w;
    logic [7:0]    smask, emask, nmask;
    logic [31:0]   nm32, wdata;

    logic          sel_d, wr_d, done_d;
    logic [3:0]    mask_d;
    logic [15:0]   addr_d;
    logic [31:0]   data_d;

    logic          unused_bits;
    assign unused_bits = ^data_in_i[31:10];

    // Clipped geometry and row base taken from the programmed registers at start
    assign x_sum   = 11'(x0_r) + 11'(wid_r);
    assign y_sum   = 10'(y0_r) + 10'(hei_r);
    assign x_end_c = (x_sum > FB_W_X) ? FB_W_X[9:0] : x_sum[9:0];
    assign y_end_c = (y_sum > FB_H_Y) ? FB_H_Y[8:0] : y_sum[8:0];
    assign empty_c = ({2'b00, x0_r} >= FB_W_X) || ({2'b00, y0_r} >= FB_H_Y) ||
                     (wid_r == 10'd0) || (hei_r == 9'd0);
    // y*53 as shift-add
    assign base_c  = (AW'(y0_r) << 5) + (AW'(y0_r) << 4) + (AW'(y0_r) << 2) + AW'(y0_r);

    // Per-word nibble coverage within the current line
    assign x_last    = 9'(x_end - 10'd1);
    assign first_w   = wx0[8:3];
    assign last_w    = x_last[8:3];
    assign smask     = (wcur == first_w) ? (8'hFF << wx0[2:0]) : 8'hFF;
    assign emask     = (wcur == last_w) ? (8'hFF >> (3'd7 - x_last[2:0])) : 8'hFF;
    assign nmask     = smask & emask;
    assign full      = &nmask;
    assign last_word = (wcur == last_w);
    assign wy_inc    = wy + 9'd1;
    assign bus_done  = m_sel_o && m_ack_i;
    assign busy      = go || (state != S_IDLE);

    always_comb begin
        nm32 = '0;
        for (int i = 0; i < 8; i++) nm32[4*i +: 4] = {4{nmask[i]}};
        wdata = (rd_data & ~nm32) | ({8{wcol}} & nm32);
    end

    // CPU register port
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            ack_o      <= 1'b0;
            data_out_o <= '0;
            x0_r       <= '0;
            y0_r       <= '0;
            wid_r      <= '0;
            hei_r      <= '0;
            col_r      <= '0;
            go         <= 1'b0;
        end else begin
            ack_o      <= sel_i && !ack_o;
            data_out_o <= '0;
            if (state == S_IDLE && go) go <= 1'b0;
            if (sel_i && !ack_o) begin
                if (wr_en_i) begin
                    case (address_in_i)
                        3'd0: if (data_in_i[0] && state == S_IDLE && !go) go <= 1'b1;
                        3'd1: x0_r  <= data_in_i[8:0];
                        3'd2: y0_r  <= data_in_i[7:0];
                        3'd3: wid_r <= data_in_i[9:0];
                        3'd4: hei_r <= data_in_i[8:0];
                        3'd5: col_r <= data_in_i[3:0];
                        default: ;
                    endcase
                end else begin
                    case (address_in_i)
                        3'd0: data_out_o <= 32'(busy);
                        3'd1: data_out_o <= 32'(x0_r);
                        3'd2: data_out_o <= 32'(y0_r);
                        3'd3: data_out_o <= 32'(wid_r);
                        3'd4: data_out_o <= 32'(hei_r);
                        3'd5: data_out_o <= 32'(col_r);
                        default: data_out_o <= '0;
                    endcase
                end
            end
        end
    end

    // State, registered bus outputs and working datapath
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            state       <= S_IDLE;
            m_sel_o     <= 1'b0;
            m_wr_en_o   <= 1'b0;
            m_wr_mask_o <= '0;
            m_address_o <= '0;
            m_data_o    <= '0;
            done_o      <= 1'b0;
            wx0         <= '0;
            wy          <= '0;
            y_end       <= '0;
            x_end       <= '0;
            wcol        <= '0;
            row_base    <= '0;
            waddr       <= '0;
            wcur        <= '0;
            rd_data     <= '0;
            empty       <= 1'b0;
        end else begin
            state       <= state_d;
            m_sel_o     <= sel_d;
            m_wr_en_o   <= wr_d;
            m_wr_mask_o <= mask_d;
            m_address_o <= addr_d;
            m_data_o    <= data_d;
            done_o      <= done_d;
            case (state)
                S_IDLE: if (go) begin
                    wx0      <= x0_r;
                    wy       <= 9'(y0_r);
                    y_end    <= y_end_c;
                    x_end    <= x_end_c;
                    wcol     <= col_r;
                    row_base <= base_c;
                    empty    <= empty_c;
                end
                S_ROW: begin
                    wcur  <= first_w;
                    waddr <= row_base + AW'(first_w);
                end
                S_RD: if (bus_done) rd_data <= m_data_i;
                S_WR: if (bus_done && !last_word) begin
                    wcur  <= wcur + 6'd1;
                    waddr <= waddr + AW'(1);
                end
                S_NEXT: begin
                    row_base <= row_base + WPL_A;
                    wy       <= wy_inc;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: if (go) state_d = S_ROW;
            S_ROW:  state_d = empty ? S_DONE : S_WORD;
            S_WORD: state_d = full ? S_WR : S_RD;
            S_RD:   if (bus_done) state_d = S_WR;
            S_WR:   if (bus_done) state_d = last_word ? S_NEXT : S_WORD;
            S_NEXT: state_d = (wy_inc == y_end) ? S_DONE : S_ROW;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered bus outputs; sel drops for a cycle after every ack
    always_comb begin
        sel_d  = 1'b0;
        wr_d   = 1'b0;
        mask_d = m_wr_mask_o;
        addr_d = m_address_o;
        data_d = m_data_o;
        done_d = (state_d == S_DONE);
        case (state)
            S_WORD: begin
                sel_d  = 1'b1;
                wr_d   = full;
                mask_d = 4'hF;
                addr_d = {1'b0, waddr};
                data_d = wdata;
            end
            S_RD: sel_d = !bus_done;
            S_WR: if (!bus_done) begin
                sel_d  = 1'b1;
                wr_d   = 1'b1;
                data_d = wdata;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_vga_fill.sv
// Directed bench for vga_fill: a VRAM model answers the master port and a scoreboard
// of expected VRAM transactions is filled by a pixel-level reference model.
module tb_vga_fill;
    logic        clk = 1'b0;
    logic        reset_ni;
    logic        sel_i, wr_en_i;
    logic [2:0]  address_in_i;
    logic [31:0] data_in_i, data_out_o;
    logic        ack_o, m_sel_o, m_wr_en_o, m_ack_i, done_o;
    logic [3:0]  m_wr_mask_o;
    logic [15:0] m_address_o;
    logic [31:0] m_data_o, m_data_i;

    always #5 clk = ~clk;

    vga_fill dut (
        .clk(clk), .reset_ni(reset_ni), .sel_i(sel_i), .wr_en_i(wr_en_i),
        .address_in_i(address_in_i), .data_in_i(data_in_i), .data_out_o(data_out_o),
        .ack_o(ack_o), .m_sel_o(m_sel_o), .m_wr_en_o(m_wr_en_o), .m_wr_mask_o(m_wr_mask_o),
        .m_address_o(m_address_o), .m_data_o(m_data_o), .m_data_i(m_data_i),
        .m_ack_i(m_ack_i), .done_o(done_o)
    );

    typedef struct { bit wr; int addr; logic [31:0] data; } txn_t;
    txn_t        exp_q[$];
    logic [31:0] mem [int];
    logic [31:0] ref_mem [int];
    int n_cmp = 0, n_err = 0, done_cnt = 0, sel_cycles = 0;
    bit ignore_bus = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // VRAM: ack one cycle after sel
    always @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            m_ack_i <= 1'b0;
            m_data_i <= '0;
        end else if (m_sel_o && !m_ack_i) begin
            m_ack_i <= 1'b1;
            if (m_wr_en_o) mem[int'(m_address_o)] = m_data_o;
            else m_data_i <= mem.exists(int'(m_address_o)) ? mem[int'(m_address_o)] : 32'h0;
        end else begin
            m_ack_i <= 1'b0;
        end
    end

    // Bus monitor: every acked transaction is checked against the scoreboard
    always @(negedge clk) begin
        txn_t t;
        if (done_o) done_cnt++;
        if (m_sel_o) sel_cycles++;
        if (m_sel_o && m_ack_i && !ignore_bus) begin
            if (exp_q.size() == 0) t = '{wr: 1'b1, addr: -1, data: 32'hDEAD_BEEF};
            else t = exp_q.pop_front();
            chk("txn_wr", 32'(m_wr_en_o), 32'(t.wr));
            chk("txn_addr", 32'(m_address_o), 32'(t.addr));
            chk("addr_range", 32'(m_address_o <= 16'd12719), 32'd1);
            if (t.wr) begin
                chk("txn_data", m_data_o, t.data);
                chk("txn_mask", 32'(m_wr_mask_o), 32'hF);
            end
        end
    end

    task automatic model_fill(input int x0, input int y0, input int w, input int h,
                              input logic [3:0] c);
        int xe, ye;
        logic [31:0] fill, m, old;
        txn_t t;
        if (x0 >= 424 || y0 >= 240 || w == 0 || h == 0) return;
        xe = (x0 + w > 424) ? 424 : x0 + w;
        ye = (y0 + h > 240) ? 240 : y0 + h;
        fill = {8{c}};
        for (int y = y0; y < ye; y++) begin
            for (int wd = x0 / 8; wd <= (xe - 1) / 8; wd++) begin
                int a;
                a = y * 53 + wd;
                m = '0;
                for (int p = 0; p < 8; p++)
                    if (wd * 8 + p >= x0 && wd * 8 + p < xe) m[4*p +: 4] = 4'hF;
                old = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
                if (m != 32'hFFFF_FFFF) begin
                    t.wr = 1'b0; t.addr = a; t.data = old;
                    exp_q.push_back(t);
                end
                t.wr = 1'b1; t.addr = a; t.data = (old & ~m) | (fill & m);
                exp_q.push_back(t);
                ref_mem[a] = t.data;
            end
        end
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        sel_i = 1'b1; wr_en_i = 1'b1; address_in_i = a; data_in_i = d;
        @(negedge clk);
        sel_i = 1'b0; wr_en_i = 1'b0;
    endtask

    task automatic rd_reg(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        sel_i = 1'b1; wr_en_i = 1'b0; address_in_i = a;
        @(negedge clk);
        chk("rd_ack", 32'(ack_o), 32'd1);
        d = data_out_o;
        sel_i = 1'b0;
    endtask

    task automatic prog(input int x0, input int y0, input int w, input int h,
                        input logic [3:0] c, input bit model);
        wr_reg(3'd1, 32'(x0)); wr_reg(3'd2, 32'(y0)); wr_reg(3'd3, 32'(w));
        wr_reg(3'd4, 32'(h));  wr_reg(3'd5, 32'(c));
        if (model) model_fill(x0, y0, w, h, c);
    endtask

    task automatic finish_fill(input string tag, input int d0);
        int cyc;
        cyc = 0;
        while (done_cnt == d0 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (12) @(negedge clk);
        chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int d0, s0, cyc;
        reset_ni = 1'b0; sel_i = 1'b0; wr_en_i = 1'b0; address_in_i = '0; data_in_i = '0;
        #1;
        chk("rst_ack", 32'(ack_o), 32'd0);
        chk("rst_m_sel", 32'(m_sel_o), 32'd0);
        chk("rst_m_wr_en", 32'(m_wr_en_o), 32'd0);
        chk("rst_m_mask", 32'(m_wr_mask_o), 32'd0);
        chk("rst_m_addr", 32'(m_address_o), 32'd0);
        chk("rst_m_data", m_data_o, 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_dout", data_out_o, 32'd0);
        repeat (2) @(negedge clk);
        reset_ni = 1'b1;

        rd_reg(3'd0, rd); chk("rst_busy", rd, 32'd0);
        rd_reg(3'd5, rd); chk("rst_color", rd, 32'd0);
        wr_reg(3'd1, 32'hFFFF_FFFF); rd_reg(3'd1, rd); chk("x0_readback", rd, 32'h1FF);
        wr_reg(3'd6, 32'h1234_5678); rd_reg(3'd6, rd); chk("reg6_zero", rd, 32'd0);

        // Full line of full words
        prog(0, 0, 424, 1, 4'h5, 1'b1);
        d0 = done_cnt; wr_reg(3'd0, 32'd1);
        finish_fill("line0", d0);

        // Single-word RMW
        mem[106] = 32'h1234_5678; ref_mem[106] = 32'h1234_5678;
        prog(3, 2, 2, 1, 4'hA, 1'b1);
        d0 = done_cnt; wr_reg(3'd0, 32'd1);
        finish_fill("single", d0);
        chk("single_mem", mem[106], 32'h123A_A678);

        // Three-word rows; geometry write and restart while busy must not disturb it
        foreach (ref_mem[k]) ;
        for (int a = 530; a < 533; a++) begin
            mem[a] = $urandom; ref_mem[a] = mem[a];
            mem[a+53] = $urandom; ref_mem[a+53] = mem[a+53];
        end
        prog(6, 10, 12, 2, 4'hF, 1'b1);
        d0 = done_cnt; wr_reg(3'd0, 32'd1);
        rd_reg(3'd0, rd); chk("busy_running", rd, 32'd1);
        wr_reg(3'd1, 32'd0);
        wr_reg(3'd0, 32'd1);
        finish_fill("rows", d0);
        rd_reg(3'd1, rd); chk("x0_busy_write", rd, 32'd0);
        rd_reg(3'd0, rd); chk("busy_after", rd, 32'd0);

        // Clipped bottom-right corner
        mem[12666] = $urandom; ref_mem[12666] = mem[12666];
        mem[12719] = $urandom; ref_mem[12719] = mem[12719];
        prog(420, 238, 100, 100, 4'h3, 1'b1);
        d0 = done_cnt; wr_reg(3'd0, 32'd1);
        finish_fill("clip", d0);

        // Empty fills: no bus traffic, done two cycles after the start ack
        for (int k = 0; k < 2; k++) begin
            if (k == 0) prog(10, 10, 0, 5, 4'h3, 1'b1);
            else prog(500, 10, 8, 5, 4'h3, 1'b1);
            s0 = sel_cycles; d0 = done_cnt;
            wr_reg(3'd0, 32'd1);
            @(negedge clk); chk("empty_done_c1", 32'(done_o), 32'd0);
            @(negedge clk); chk("empty_done_c2", 32'(done_o), 32'd1);
            @(negedge clk); chk("empty_done_c3", 32'(done_o), 32'd0);
            repeat (4) @(negedge clk);
            chk("empty_no_sel", 32'(sel_cycles - s0), 32'd0);
            chk("empty_pulses", 32'(done_cnt - d0), 32'd1);
        end

        // Reset in the middle of a fill
        ignore_bus = 1'b1;
        prog(0, 0, 424, 240, 4'h7, 1'b0);
        d0 = done_cnt; wr_reg(3'd0, 32'd1);
        repeat (20) @(negedge clk);
        cyc = 0;
        while (!m_sel_o && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("midfill_sel_seen", 32'(m_sel_o), 32'd1);
        #2 reset_ni = 1'b0;
        #1;
        chk("midfill_rst_sel", 32'(m_sel_o), 32'd0);
        chk("midfill_rst_wr", 32'(m_wr_en_o), 32'd0);
        chk("midfill_rst_done", 32'(done_o), 32'd0);
        @(negedge clk);
        reset_ni = 1'b1;
        ref_mem = mem;
        ignore_bus = 1'b0;
        rd_reg(3'd0, rd); chk("midfill_busy", rd, 32'd0);
        chk("midfill_no_pulse", 32'(done_cnt - d0), 32'd0);

        prog(100, 50, 20, 3, 4'h9, 1'b1);
        d0 = done_cnt; wr_reg(3'd0, 32'd1);
        finish_fill("after_rst", d0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
